edulent_ctrl_fsm: RTL and testbench
===================================

// Module: edulent_ctrl_fsm
// PURPOSE
// Instruction sequencer for data_path: fetches and decodes each opcode and drives one register-transfer command per cycle.
// Also drives PC/SP steps, ALU strobes and the memory request/ack handshake.
// Sits between data_path (i_ir taps its IR register) and the memory bus.
// PARAMETERS
// MEM_TIMEOUT  255  max wait cycles for i_mem_ack before bus error; 0 = never time out
// PORTS
// i_clk            in   1  clock
// i_rstn           in   1  asynchronous, active-low reset
// i_run            in   1  level: start from IDLE / keep running at instruction boundaries
// i_ir             in   8  current IR value from data_path
// i_mem_ack        in   1  memory transfer complete (1 cycle)
// o_mem_req        out  1  memory request, held until ack
// o_mem_we         out  1  write qualifier, valid with o_mem_req
// o_transfer_cmd   out  4  data_path transfer code (0=none,1..F)
// o_inc_pc         out  1  PC+1 this cycle
// o_inc_dec_sp     out  2  01=SP+1, 10=SP-1, 00=hold
// o_alu_calculate  out  1  R <= ALU(IR[7:4])
// o_alu_res_to_ap  out  1  cmd A writes AP instead of A
// o_next_instr     out  1  pulse: first cycle of a fetch
// o_illegal        out  1  pulse: undefined opcode decoded
// o_bus_err        out  1  sticky: memory timeout
// o_halted         out  1  HALT state
// BEHAVIOUR
// - Reset (async): state IDLE, timeout counter 0; every output 0, including sticky o_bus_err.
// - Outputs are decoded from registered state plus i_mem_ack; exactly one transfer code per cycle.
// - IDLE: go to F_MA when i_run=1.
// - Fetch: F_MA cmd1 + o_next_instr -> F_RD req until ack, cmd2 in ack cycle -> F_IR cmd3 + inc_pc -> DEC.
// - DEC samples i_ir; opcode groups:
//   NOP 00: end.
//   LDI 11/13: operand fetch, then WB cmd5.
//   LD 19/1B: operand fetch, AM cmd4, D_RD (req, cmd2 on ack), WB cmd5.
//   ST 21/23: operand fetch, AM cmd4, S_MD cmd8, S_WR cmd9, S_WT (req+we until ack).
//   PUSH 2C/2E: P_MA cmd7, S_MD cmd8, S_WR cmd9, S_WT; SP-1 in the ack cycle.
//   POP 14/1C/1E: Q_INC sp=01, Q_MA cmd7, D_RD, WB cmd5.
//   ALU 3x,4x,6x,7x,8x: operand fetch, EX alu_calculate, AWB cmd A, res_to_ap=IR[3].
//   ALU 5x,9x: no operand; EX, then AWB.
//   JMP B0: operand fetch, then cmdB.
//   IN C0: cmdC.  OUT D0: cmdD.  JAP E0: cmdE.  HALT FF: enter HALT.
// - Operand fetch: O_MA cmd1 -> O_RD req, cmd2 + inc_pc in ack cycle.
// - Undefined opcode: o_illegal for 1 cycle in DEC; then treated as NOP.
// - Instruction end: go to F_MA if i_run=1, else IDLE. i_run is ignored mid-instruction.
// - Timing with 1-cycle ack:
//   NOP = 4 cycles (F_MA..DEC). LDI = 7. PUSH = 8 (last cycle is S_WT).
// - Wait states are F_RD, O_RD, D_RD and S_WT.
//   o_mem_req stays high in a wait state until i_mem_ack; o_mem_we is high only in S_WT.
//   i_mem_ack outside a wait state is ignored.
// - Timeout: counter increments each unacked wait cycle and clears on ack or state exit.
//   On reaching MEM_TIMEOUT: o_bus_err<=1, go to HALT, no cmd issued.
// - HALT: all strobes 0, o_halted=1; exit only via reset.
// - Reset mid-instruction aborts immediately; no partial command is completed.
// TESTING
// - NOP (00) with 1-cycle ack -> cmd sequence 1,2,3,0 with inc_pc in cycle 3; next o_next_instr 4 cycles later.
// - LDI A (11, operand 5A), ack delayed 3 cycles on each read -> req held 3 cycles each; cmd 1,2,3,0,1,2,5; inc_pc pulses exactly twice.
// - PUSH A (2C) -> cmds 7,8,9; req+we held until ack; o_inc_dec_sp=10 for exactly one cycle.
// - ALU 38 (operand 02) -> alu_calculate one cycle, then cmd A with o_alu_res_to_ap=1; ALU 50 -> no operand fetch.
// - i_mem_ack never asserted, MEM_TIMEOUT=4 -> o_bus_err=1 and o_halted=1 after 4 wait cycles; reset clears both.
// - Opcode 77 -> o_illegal 1-cycle pulse, next fetch follows. i_run=0 during an instruction -> instruction completes, then IDLE.

Source files
------------

// File: rtl/edulent_ctrl_fsm.sv
// edulent_ctrl_fsm: instruction sequencer for data_path. Fetches an opcode,
// decodes it from the IR tap, then steps through one register-transfer
// command per cycle while driving PC/SP steps, ALU strobes and the memory
// request/acknowledge handshake. A wait that outlasts MEM_TIMEOUT raises a
// sticky bus error and parks the sequencer in HALT until reset.
// ALU opcodes need IR[2:0] = 000 (IR[3] selects AP as the destination), so
// codes such as 77 in an ALU row decode as illegal.
module edulent_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_run,
  input  logic [7:0] i_ir,
  input  logic       i_mem_ack,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic [3:0] o_transfer_cmd,
  output logic       o_inc_pc,
  output logic [1:0] o_inc_dec_sp,
  output logic       o_alu_calculate,
  output logic       o_alu_res_to_ap,
  output logic       o_next_instr,
  output logic       o_illegal,
  output logic       o_bus_err,
  output logic       o_halted
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(MEM_TIMEOUT);

  typedef enum logic [4:0] {
    S_IDLE, S_F_MA, S_F_RD, S_F_IR, S_DEC,
    S_O_MA, S_O_RD, S_AM, S_D_RD, S_WB,
    S_S_MD, S_S_WR, S_S_WT, S_P_MA, S_Q_INC,
    S_Q_MA, S_EX, S_AWB, S_JP, S_IO, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LD, OP_ST, OP_PUSH, OP_POP, OP_ALU_OPND, OP_ALU,
    OP_JMP, OP_IN, OP_OUT, OP_JAP, OP_HALT, OP_ILL
  } op_e;

  function automatic op_e classify(input logic [7:0] ir);
    op_e c;
    c = OP_ILL;
    case (ir)
      8'h00:               c = OP_NOP;
      8'h11, 8'h13:        c = OP_LDI;
      8'h19, 8'h1B:        c = OP_LD;
      8'h21, 8'h23:        c = OP_ST;
      8'h2C, 8'h2E:        c = OP_PUSH;
      8'h14, 8'h1C, 8'h1E: c = OP_POP;
      8'hB0:               c = OP_JMP;
      8'hC0:               c = OP_IN;
      8'hD0:               c = OP_OUT;
      8'hE0:               c = OP_JAP;
      8'hFF:               c = OP_HALT;
      default: begin
        if (ir[2:0] == 3'b000) begin
          case (ir[7:4])
            4'h3, 4'h4, 4'h6, 4'h7, 4'h8: c = OP_ALU_OPND;
            4'h5, 4'h9:                   c = OP_ALU;
            default:                      c = OP_ILL;
          endcase
        end
      end
    endcase
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      instr_q, instr_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            bus_err_q, bus_err_d;
  logic            wait_miss;
  op_e             dec_op, cur_op;
  state_e          next_boundary;

  assign dec_op        = classify(i_ir);
  assign cur_op        = classify(instr_q);
  assign next_boundary = i_run ? S_F_MA : S_IDLE;
  assign o_bus_err     = bus_err_q;

  // State, latched opcode, wait counter and sticky bus error registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_IDLE;
      instr_q   <= 8'h00;
      tmo_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      tmo_q     <= tmo_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state sequencing, per-state command decode and wait timeout.
  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    tmo_d           = '0;
    bus_err_d       = bus_err_q;
    wait_miss       = 1'b0;
    o_mem_req       = 1'b0;
    o_mem_we        = 1'b0;
    o_transfer_cmd  = 4'h0;
    o_inc_pc        = 1'b0;
    o_inc_dec_sp    = 2'b00;
    o_alu_calculate = 1'b0;
    o_alu_res_to_ap = 1'b0;
    o_next_instr    = 1'b0;
    o_illegal       = 1'b0;
    o_halted        = 1'b0;
    case (state_q)
      S_IDLE: if (i_run) state_d = S_F_MA;
      S_F_MA: begin
        o_transfer_cmd = 4'h1;
        o_next_instr   = 1'b1;
        state_d        = S_F_RD;
      end
      S_F_RD: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_transfer_cmd = 4'h2;
          state_d        = S_F_IR;
        end else wait_miss = 1'b1;
      end
      S_F_IR: begin
        o_transfer_cmd = 4'h3;
        o_inc_pc       = 1'b1;
        state_d        = S_DEC;
      end
      S_DEC: begin
        instr_d = i_ir;
        case (dec_op)
          OP_LDI, OP_LD, OP_ST, OP_ALU_OPND, OP_JMP: state_d = S_O_MA;
          OP_PUSH:                    state_d = S_P_MA;
          OP_POP:                     state_d = S_Q_INC;
          OP_ALU:                     state_d = S_EX;
          OP_IN, OP_OUT, OP_JAP:      state_d = S_IO;
          OP_HALT:                    state_d = S_HALT;
          OP_ILL: begin
            o_illegal = 1'b1;
            state_d   = next_boundary;
          end
          default:                    state_d = next_boundary;
        endcase
      end
      S_O_MA: begin
        o_transfer_cmd = 4'h1;
        state_d        = S_O_RD;
      end
      S_O_RD: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_transfer_cmd = 4'h2;
          o_inc_pc       = 1'b1;
          case (cur_op)
            OP_LDI:       state_d = S_WB;
            OP_LD, OP_ST: state_d = S_AM;
            OP_ALU_OPND:  state_d = S_EX;
            default:      state_d = S_JP;
          endcase
        end else wait_miss = 1'b1;
      end
      S_AM: begin
        o_transfer_cmd = 4'h4;
        state_d        = (cur_op == OP_ST) ? S_S_MD : S_D_RD;
      end
      S_D_RD: begin
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          o_transfer_cmd = 4'h2;
          state_d        = S_WB;
        end else wait_miss = 1'b1;
      end
      S_WB: begin
        o_transfer_cmd = 4'h5;
        state_d        = next_boundary;
      end
      S_P_MA: begin
        o_transfer_cmd = 4'h7;
        state_d        = S_S_MD;
      end
      S_S_MD: begin
        o_transfer_cmd = 4'h8;
        state_d        = S_S_WR;
      end
      S_S_WR: begin
        o_transfer_cmd = 4'h9;
        state_d        = S_S_WT;
      end
      S_S_WT: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ack) begin
          if (cur_op == OP_PUSH) o_inc_dec_sp = 2'b10;
          state_d = next_boundary;
        end else wait_miss = 1'b1;
      end
      S_Q_INC: begin
        o_inc_dec_sp = 2'b01;
        state_d      = S_Q_MA;
      end
      S_Q_MA: begin
        o_transfer_cmd = 4'h7;
        state_d        = S_D_RD;
      end
      S_EX: begin
        o_alu_calculate = 1'b1;
        state_d         = S_AWB;
      end
      S_AWB: begin
        o_transfer_cmd  = 4'hA;
        o_alu_res_to_ap = instr_q[3];
        state_d         = next_boundary;
      end
      S_JP: begin
        o_transfer_cmd = 4'hB;
        state_d        = next_boundary;
      end
      S_IO: begin
        case (cur_op)
          OP_IN:   o_transfer_cmd = 4'hC;
          OP_OUT:  o_transfer_cmd = 4'hD;
          default: o_transfer_cmd = 4'hE;
        endcase
        state_d = next_boundary;
      end
      S_HALT: o_halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
    if (wait_miss && (MEM_TIMEOUT != 0)) begin
      if (tmo_q == TO_LIMIT - CW'(1)) begin
        state_d   = S_HALT;
        bus_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_edulent_ctrl_fsm.sv
// tb_edulent_ctrl_fsm: scoreboard bench for the instruction sequencer. A
// reference model expands each opcode into the expected per-cycle output
// vectors and the memory delays it will see; a memory responder acks after
// those delays, and a monitor pops and compares one vector per active cycle.
module tb_edulent_ctrl_fsm;

  localparam int TO = 4;

  logic       i_clk = 1'b0;
  logic       i_rstn = 1'b0;
  logic       i_run = 1'b0;
  logic [7:0] i_ir = 8'h00;
  logic       i_mem_ack = 1'b0;
  logic       o_mem_req, o_mem_we, o_inc_pc, o_alu_calculate, o_alu_res_to_ap;
  logic       o_next_instr, o_illegal, o_bus_err, o_halted;
  logic [3:0] o_transfer_cmd;
  logic [1:0] o_inc_dec_sp;

  edulent_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_run(i_run), .i_ir(i_ir),
    .i_mem_ack(i_mem_ack), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_transfer_cmd(o_transfer_cmd), .o_inc_pc(o_inc_pc),
    .o_inc_dec_sp(o_inc_dec_sp), .o_alu_calculate(o_alu_calculate),
    .o_alu_res_to_ap(o_alu_res_to_ap), .o_next_instr(o_next_instr),
    .o_illegal(o_illegal), .o_bus_err(o_bus_err), .o_halted(o_halted)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic req; logic we; logic [3:0] cmd; logic pc; logic [1:0] sp;
    logic alu; logic ap; logic nxt; logic ill; logic berr; logic halt;
  } vec_t;

  typedef enum int {
    K_NOP, K_LDI, K_LD, K_ST, K_PUSH, K_POP, K_ALUO, K_ALU,
    K_JMP, K_IN, K_OUT, K_JAP, K_HALT, K_ILL
  } kind_e;

  vec_t       exp_q[$];
  int         delay_q[$];
  logic [7:0] ir_q[$];
  logic [7:0] prog_op[$];
  int         prog_d[$];
  vec_t       mon_exp;
  int         total = 0;
  int         passed = 0;
  bit         armed = 1'b0;
  bit         started = 1'b0;
  int         cycles_checked = 0;
  int         req_cycles = 0;
  int         cur_delay = 1;

  logic [7:0] legal_ops [30] = '{
    8'h00, 8'h11, 8'h13, 8'h19, 8'h1B, 8'h21, 8'h23, 8'h2C, 8'h2E, 8'h14,
    8'h1C, 8'h1E, 8'h30, 8'h38, 8'h40, 8'h48, 8'h60, 8'h68, 8'h70, 8'h78,
    8'h80, 8'h88, 8'h50, 8'h58, 8'h90, 8'h98, 8'hB0, 8'hC0, 8'hD0, 8'hE0
  };

  function automatic vec_t actual();
    vec_t v;
    v.req = o_mem_req;        v.we = o_mem_we;      v.cmd = o_transfer_cmd;
    v.pc = o_inc_pc;          v.sp = o_inc_dec_sp;  v.alu = o_alu_calculate;
    v.ap = o_alu_res_to_ap;   v.nxt = o_next_instr; v.ill = o_illegal;
    v.berr = o_bus_err;       v.halt = o_halted;
    return v;
  endfunction

  function automatic vec_t c(input logic [3:0] cmd);
    vec_t v;
    v = '0;
    v.cmd = cmd;
    return v;
  endfunction

  function automatic kind_e kind_of(input logic [7:0] op);
    logic [3:0] hi;
    hi = op[7:4];
    if (op == 8'h00) return K_NOP;
    if (op inside {8'h11, 8'h13}) return K_LDI;
    if (op inside {8'h19, 8'h1B}) return K_LD;
    if (op inside {8'h21, 8'h23}) return K_ST;
    if (op inside {8'h2C, 8'h2E}) return K_PUSH;
    if (op inside {8'h14, 8'h1C, 8'h1E}) return K_POP;
    if (op == 8'hB0) return K_JMP;
    if (op == 8'hC0) return K_IN;
    if (op == 8'hD0) return K_OUT;
    if (op == 8'hE0) return K_JAP;
    if (op == 8'hFF) return K_HALT;
    if (op[2:0] == 3'b000 && (hi inside {4'h3, 4'h4, 4'h6, 4'h7, 4'h8})) return K_ALUO;
    if (op[2:0] == 3'b000 && (hi inside {4'h5, 4'h9})) return K_ALU;
    return K_ILL;
  endfunction

  // Compare the DUT's present outputs against one expected vector.
  task automatic checkOutput(input string name, input vec_t exp_v);
    vec_t act;
    act = actual();
    total++;
    if (act === exp_v) passed++;
    else $display("[TB] FAIL %s: actual %h (cmd %h) required %h (cmd %h) [req we cmd pc sp alu ap nxt ill berr halt]",
                  name, act, act.cmd, exp_v, exp_v.cmd);
  endtask

  task automatic emit(input vec_t v);
    exp_q.push_back(v);
  endtask

  task automatic pick_delay(input int dfix, output int d);
    if (dfix > 0) d = dfix;
    else if (dfix < 0) d = 0;
    else d = int'($urandom_range(1, TO));
  endtask

  // One memory transfer lasting d request cycles (0 = never acked).
  task automatic mem_access(input int d, input bit wr, input vec_t on_ack, output bit to);
    vec_t w;
    w = '0; w.req = 1'b1; w.we = wr;
    delay_q.push_back(d);
    if (d == 0 || d > TO) begin
      for (int i = 0; i < TO; i++) emit(w);
      to = 1'b1;
    end else begin
      for (int i = 1; i < d; i++) emit(w);
      on_ack.req = 1'b1; on_ack.we = wr;
      emit(on_ack);
      to = 1'b0;
    end
  endtask

  task automatic operand(input int dfix, output bit to);
    vec_t e; int d;
    emit(c(4'h1));
    pick_delay(dfix, d);
    e = c(4'h2); e.pc = 1'b1;
    mem_access(d, 1'b0, e, to);
  endtask

  // Expected cycle trace for a whole instruction.
  task automatic model_instr(input logic [7:0] op, input int dfix, output bit stop, output bit bus);
    vec_t e; bit to; int d; kind_e k;
    stop = 1'b0; bus = 1'b0; to = 1'b0;
    k = kind_of(op);
    ir_q.push_back(op);
    e = c(4'h1); e.nxt = 1'b1; emit(e);
    pick_delay(dfix, d);
    mem_access(d, 1'b0, c(4'h2), to);
    if (to) begin stop = 1'b1; bus = 1'b1; return; end
    e = c(4'h3); e.pc = 1'b1; emit(e);
    e = c(4'h0); e.ill = (k == K_ILL); emit(e);
    if (k inside {K_LDI, K_LD, K_ST, K_ALUO, K_JMP}) begin
      operand(dfix, to);
      if (to) begin stop = 1'b1; bus = 1'b1; return; end
    end
    case (k)
      K_LDI: emit(c(4'h5));
      K_LD, K_POP: begin
        if (k == K_POP) begin
          e = c(4'h0); e.sp = 2'b01; emit(e);
          emit(c(4'h7));
        end else emit(c(4'h4));
        pick_delay(dfix, d);
        mem_access(d, 1'b0, c(4'h2), to);
        if (to) begin stop = 1'b1; bus = 1'b1; return; end
        emit(c(4'h5));
      end
      K_ST, K_PUSH: begin
        emit(c((k == K_ST) ? 4'h4 : 4'h7));
        emit(c(4'h8));
        emit(c(4'h9));
        e = c(4'h0);
        if (k == K_PUSH) e.sp = 2'b10;
        pick_delay(dfix, d);
        mem_access(d, 1'b1, e, to);
        if (to) begin stop = 1'b1; bus = 1'b1; return; end
      end
      K_ALUO, K_ALU: begin
        e = c(4'h0); e.alu = 1'b1; emit(e);
        e = c(4'hA); e.ap = op[3]; emit(e);
      end
      K_JMP: emit(c(4'hB));
      K_IN:  emit(c(4'hC));
      K_OUT: emit(c(4'hD));
      K_JAP: emit(c(4'hE));
      K_HALT: stop = 1'b1;
      default: ;
    endcase
  endtask

  // Build the expected trace for prog_op/prog_d, start the DUT and let the
  // monitor drain it; i_run drops during the last instruction.
  task automatic applyStimulus(input string name);
    bit stop, bus; int last_start; int budget; vec_t e;
    exp_q.delete(); delay_q.delete(); ir_q.delete();
    stop = 1'b0; bus = 1'b0; last_start = 0;
    for (int i = 0; i < prog_op.size(); i++) begin
      last_start = exp_q.size();
      model_instr(prog_op[i], prog_d[i], stop, bus);
      if (stop) break;
    end
    for (int i = 0; i < 3; i++) begin
      e = '0; e.halt = stop; e.berr = bus; emit(e);
    end
    cycles_checked = 0; started = 1'b0;
    @(negedge i_clk); #1;
    armed = 1'b1; i_run = 1'b1;
    budget = 0;
    while (armed && budget < 5000) begin
      @(negedge i_clk); #1;
      budget++;
      if (!stop && i_run && cycles_checked > last_start) i_run = 1'b0;
    end
    if (armed) begin
      total++;
      $display("[TB] FAIL %s: scoreboard not drained, %0d entries left, required 0", name, exp_q.size());
      armed = 1'b0; started = 1'b0; exp_q.delete();
    end
    i_run = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge i_clk);
    i_rstn = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
  endtask

  task automatic add(input logic [7:0] op, input int d);
    prog_op.push_back(op);
    prog_d.push_back(d);
  endtask

  // Monitor: once the first fetch appears, compare every cycle to the queue.
  always @(negedge i_clk) begin
    if (armed && i_rstn) begin
      if (!started && o_next_instr) started = 1'b1;
      if (started) begin
        mon_exp = exp_q.pop_front();
        checkOutput($sformatf("cycle%0d", cycles_checked), mon_exp);
        cycles_checked++;
        if (exp_q.size() == 0) begin
          armed = 1'b0;
          started = 1'b0;
        end
      end
    end
  end

  // IR emulation: data_path loads IR during the command-3 cycle.
  always @(negedge i_clk) begin
    if (o_transfer_cmd == 4'h3 && ir_q.size() > 0) i_ir = ir_q.pop_front();
  end

  // Memory responder: ack on the d-th cycle of each request (d = 0 never).
  always begin
    @(posedge i_clk);
    #1;
    if (o_mem_req) begin
      if (req_cycles == 0) cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
      req_cycles++;
      i_mem_ack = (cur_delay != 0) && (req_cycles == cur_delay);
      if (i_mem_ack) req_cycles = 0;
    end else begin
      i_mem_ack = 1'b0;
      req_cycles = 0;
    end
  end

  initial begin
    logic [7:0] op;
    i_rstn = 1'b0;
    i_run = 1'b1;
    repeat (2) @(negedge i_clk);
    #1 checkOutput("reset_state", '0);
    i_run = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);
    #1 checkOutput("idle_after_reset", '0);

    prog_op.delete(); prog_d.delete();
    add(8'h00, 1); add(8'h11, 3); add(8'h2C, 1); add(8'h38, 1);
    add(8'h50, 1); add(8'h77, 1); add(8'h21, 4); add(8'h19, 2);
    add(8'h14, 1); add(8'hB0, 1); add(8'hC0, 1); add(8'hD0, 1);
    add(8'hE0, 1); add(8'h1E, 0); add(8'h2E, 0); add(8'h48, 0);
    add(8'h98, 0); add(8'h1B, 0); add(8'h23, 0); add(8'h1C, 0);
    add(8'h13, 0); add(8'h58, 0);
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) op = 8'($urandom_range(0, 254));
      else op = legal_ops[$urandom_range(0, 29)];
      add(op, 0);
    end
    add(8'h11, 0);
    applyStimulus("main_program");

    prog_op.delete(); prog_d.delete();
    add(8'h11, 0); add(8'hFF, 0);
    applyStimulus("halt_program");
    pulse_reset();
    #1 checkOutput("reset_leaves_halt", '0);

    prog_op.delete(); prog_d.delete();
    add(8'h00, -1);
    applyStimulus("timeout_program");
    pulse_reset();
    #1 checkOutput("reset_clears_bus_err", '0);

    exp_q.delete(); delay_q.delete(); ir_q.delete();
    i_ir = 8'h21;
    i_run = 1'b1;
    repeat (9) @(negedge i_clk);
    #2 i_rstn = 1'b0;
    #1 checkOutput("async_reset_abort", '0);
    i_run = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (3) @(negedge i_clk);
    #1 checkOutput("idle_after_abort", '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
